// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: registered csN/oeN/wrN/addr/data sequencer for the 1K x 8 asynchronous simplemem array
module sram_bus_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              mem_csN,
  output logic              mem_oeN,
  output logic              mem_wrN,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, drv_q;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic cs_n_q, oe_n_q, wr_n_q, ack_q, busy_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        we_d = we;
        wdata_d = we ? wdata : wdata_q;
        addr_d = addr;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d = we_q ? 4'(WR_WAIT) : 4'(RD_WAIT);
      end
      STROBE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = HOLD;
          rdata_d = we_q ? rdata_q : mem_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Pin values are decoded from the next state so every memory-side output is a flop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      addr_q <= '0;
      rdata_q <= '0;
      cs_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      drv_q <= 1'b0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      rdata_q <= rdata_d;
      cs_n_q <= state_d == IDLE;
      oe_n_q <= !(state_d == STROBE && !we_d);
      wr_n_q <= !(state_d == STROBE && we_d);
      drv_q <= state_d != IDLE && we_d;
      ack_q <= state_d == HOLD;
      busy_q <= state_d != IDLE;
    end
  end
  assign mem_data = drv_q ? wdata_q : 'z;
  assign mem_addr = addr_q;
  assign mem_csN = cs_n_q;
  assign mem_oeN = oe_n_q;
  assign mem_wrN = wr_n_q;
  assign rdata = rdata_q;
  assign ack = ack_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: directed checks of sram_bus_ctrl at default, (RD=1,WR=15) and (RD=15,WR=1) wait settings
module tb_sram_bus_ctrl;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [2:0] req = '0, we = '0;
  logic [2:0][9:0] ad = '0;
  logic [2:0][7:0] wd = '0;
  wire [2:0] cs, oe, wr, ack, busy;
  wire [2:0][9:0] ma;
  wire [2:0][7:0] rd;
  wire [7:0] md0, md1, md2;
  wire [2:0][7:0] mdv = {md2, md1, md0};
  logic [7:0] mem [1024] = '{default: 8'h00};
  int n_cmp = 0, n_err = 0, inv_err = 0;
  logic mon_on = 1'b0;
  logic [2:0] pcs = '1;
  logic [2:0][9:0] pma = '0;
  always #5 clk = ~clk;

  sram_bus_ctrl u0 (.clk(clk), .rstN(rstN), .req(req[0]), .we(we[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rd[0]), .ack(ack[0]), .busy(busy[0]), .mem_csN(cs[0]), .mem_oeN(oe[0]), .mem_wrN(wr[0]),
    .mem_addr(ma[0]), .mem_data(md0));
  sram_bus_ctrl #(.RD_WAIT(1), .WR_WAIT(15)) u1 (.clk(clk), .rstN(rstN), .req(req[1]), .we(we[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .ack(ack[1]), .busy(busy[1]), .mem_csN(cs[1]),
    .mem_oeN(oe[1]), .mem_wrN(wr[1]), .mem_addr(ma[1]), .mem_data(md1));
  sram_bus_ctrl #(.RD_WAIT(15), .WR_WAIT(1)) u2 (.clk(clk), .rstN(rstN), .req(req[2]), .we(we[2]),
    .addr(ad[2]), .wdata(wd[2]), .rdata(rd[2]), .ack(ack[2]), .busy(busy[2]), .mem_csN(cs[2]),
    .mem_oeN(oe[2]), .mem_wrN(wr[2]), .mem_addr(ma[2]), .mem_data(md2));

  // Asynchronous memory: write on the rising edge of wrN while selected; read drives while oeN is low.
  assign md0 = (!cs[0] && !oe[0]) ? mem[ma[0]] : 8'hzz;
  assign md1 = (!cs[1] && !oe[1]) ? 8'h5B : 8'hzz;
  assign md2 = (!cs[2] && !oe[2]) ? 8'h5C : 8'hzz;
  always @(posedge wr[0]) if (cs[0] === 1'b0) mem[ma[0]] = md0;

  always @(negedge clk) begin
    if (mon_on) for (int i = 0; i < 3; i++) begin
      if (!oe[i] && !wr[i]) begin inv_err++; $display("FAIL inv%0d oe_wr_both_low got 1 want 0", i); end
      if (cs[i] && (!oe[i] || !wr[i])) begin inv_err++; $display("FAIL inv%0d strobe_without_cs got 1 want 0", i); end
      if (!oe[i] && $isunknown(mdv[i])) begin inv_err++; $display("FAIL inv%0d contention got %h want known", i, mdv[i]); end
      if (cs[i] && mdv[i] !== 8'hzz) begin inv_err++; $display("FAIL inv%0d bus_idle got %h want zz", i, mdv[i]); end
      if (!cs[i] && !pcs[i] && ma[i] != pma[i]) begin inv_err++; $display("FAIL inv%0d addr_moved got %h want %h", i, ma[i], pma[i]); end
      pcs[i] = cs[i];
      pma[i] = ma[i];
    end
  end

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s got %0h want %0h", t, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle; lat counts cycles after the sampling edge until ack (0 = none).
  task automatic txn(input int i, input logic w, input logic [9:0] a, input logic [7:0] d,
                     output int lat, output int wl, output int ol, output logic [7:0] ws,
                     output logic [9:0] as, output logic [7:0] rv);
    req[i] = 1'b1; we[i] = w; ad[i] = a; wd[i] = d;
    cyc();
    req[i] = 1'b0;
    lat = 0; wl = 0; ol = 0; ws = 'x; as = 'x; rv = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (!wr[i]) begin wl++; ws = mdv[i]; as = ma[i]; end
      if (!oe[i]) ol++;
      if (ack[i]) begin lat = k; rv = rd[i]; break; end
      cyc();
    end
    cyc();
  endtask

  initial begin
    int lat, wl, ol, na, nack;
    int at [4];
    logic [7:0] ws, rv, rb;
    logic [9:0] as;
    logic [7:0] ar [4];
    repeat (2) cyc();
    chk("rst_csN", cs[0], 1);
    chk("rst_oeN", oe[0], 1);
    chk("rst_wrN", wr[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ack", ack[0], 0);
    chk("rst_addr", ma[0], 0);
    chk("rst_rdata", rd[0], 0);
    chk("rst_bus_z", md0 === 8'hzz, 1);
    rstN = 1'b1;
    cyc();
    mon_on = 1'b1;
    // Write then read at 0x123: WAIT=2 puts HOLD/ack 4 cycles after the sampling edge.
    txn(0, 1'b1, 10'h123, 8'hA5, lat, wl, ol, ws, as, rv);
    chk("w_lat", lat, 4);
    chk("w_wrN_width", wl, 2);
    chk("w_oeN_width", ol, 0);
    chk("w_data", ws, 8'hA5);
    chk("w_addr", as, 10'h123);
    chk("w_mem", mem[10'h123], 8'hA5);
    txn(0, 1'b0, 10'h123, 8'h00, lat, wl, ol, ws, as, rv);
    chk("r_lat", lat, 4);
    chk("r_oeN_width", ol, 2);
    chk("r_wrN_width", wl, 0);
    chk("r_data_ack", rv, 8'hA5);
    chk("r_data_hold", rd[0], 8'hA5);
    // Back-to-back with req held high: acks spaced by WAIT+3 cycles.
    we[0] = 1'b1; ad[0] = 10'h000; wd[0] = 8'h11; req[0] = 1'b1; na = 0;
    for (int k = 1; k <= 60 && na < 4; k++) begin
      cyc();
      if (ack[0]) begin
        at[na] = k; ar[na] = rd[0]; na++;
        if (na == 1) begin ad[0] = 10'h3FF; wd[0] = 8'h22; end
        else if (na == 2) begin we[0] = 1'b0; ad[0] = 10'h000; end
        else if (na == 3) ad[0] = 10'h3FF;
        else req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    cyc();
    chk("b2b_acks", na, 4);
    chk("b2b_first", at[0], 4);
    chk("b2b_gap1", at[1] - at[0], 5);
    chk("b2b_gap2", at[2] - at[1], 5);
    chk("b2b_gap3", at[3] - at[2], 5);
    chk("b2b_mem0", mem[10'h000], 8'h11);
    chk("b2b_mem3ff", mem[10'h3FF], 8'h22);
    chk("b2b_rd0", ar[2], 8'h11);
    chk("b2b_rd3ff", ar[3], 8'h22);
    // Wait-state extremes on the two alternate instances.
    txn(1, 1'b1, 10'h010, 8'h3C, lat, wl, ol, ws, as, rv);
    chk("u1_w_lat", lat, 17);
    chk("u1_w_width", wl, 15);
    chk("u1_w_data", ws, 8'h3C);
    txn(1, 1'b0, 10'h010, 8'h00, lat, wl, ol, ws, as, rv);
    chk("u1_r_lat", lat, 3);
    chk("u1_r_width", ol, 1);
    chk("u1_r_data", rv, 8'h5B);
    txn(2, 1'b1, 10'h200, 8'h4D, lat, wl, ol, ws, as, rv);
    chk("u2_w_lat", lat, 3);
    chk("u2_w_width", wl, 1);
    chk("u2_w_addr", as, 10'h200);
    txn(2, 1'b0, 10'h200, 8'h00, lat, wl, ol, ws, as, rv);
    chk("u2_r_lat", lat, 17);
    chk("u2_r_width", ol, 15);
    chk("u2_r_data", rv, 8'h5C);
    // Inputs wiggled while busy must not disturb the latched write.
    rb = rd[0];
    req[0] = 1'b1; we[0] = 1'b1; ad[0] = 10'h055; wd[0] = 8'h77;
    cyc();
    req[0] = 1'b0; ad[0] = 10'h0AA; wd[0] = 8'hEE;
    cyc();
    req[0] = 1'b1; we[0] = 1'b0;
    cyc();
    req[0] = 1'b0; nack = 0;
    for (int k = 0; k < 8; k++) begin
      if (ack[0]) nack++;
      cyc();
    end
    chk("busy_acks", nack, 1);
    chk("busy_mem55", mem[10'h055], 8'h77);
    chk("busy_memaa", mem[10'h0AA], 8'h00);
    chk("busy_rdata_kept", rd[0], rb);
    // Reset dropped during a read strobe, between clock edges.
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = 10'h123;
    cyc();
    req[0] = 1'b0;
    cyc();
    chk("abort_in_strobe", oe[0], 0);
    #2 rstN = 1'b0;
    #1;
    chk("abort_csN", cs[0], 1);
    chk("abort_oeN", oe[0], 1);
    chk("abort_wrN", wr[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_ack", ack[0], 0);
    chk("abort_rdata", rd[0], 0);
    chk("abort_bus_z", md0 === 8'hzz, 1);
    cyc();
    cyc();
    rstN = 1'b1;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      if (ack[0]) nack++;
      cyc();
    end
    chk("abort_no_ack", nack, 0);
    txn(0, 1'b0, 10'h3FF, 8'h00, lat, wl, ol, ws, as, rv);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", rv, 8'h22);
    chk("invariants", inv_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
